// File: rtl/mips_fetch_stage.sv
// MIPS instruction fetch stage: PC, synchronous imem requests, small instruction FIFO, branch redirect.
// Optional macro FETCH_BYPASS_EN presents a response arriving into an empty FIFO combinationally.
module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          AW       = 6,
  parameter int          DEPTH    = 2
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  input  logic          dec_ready,
  output logic          instr_valid,
  output logic [31:0]   instr,
  output logic [31:0]   pcplus4
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [31:0]   pc;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc4   [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          inflight;
  logic [31:0]   tag;
  logic          discard;

  logic          fifo_empty;
  logic          rsp_valid;
  logic          bypass;
  logic          pop;
  logic          fifo_pop;
  logic          push;
  logic [CW-1:0] occupancy;
  logic [31:0]   target;

  assign fifo_empty = (count == '0);
  // A response is usable only if it was not issued before a redirect.
  assign rsp_valid  = inflight & ~discard & ~redirect;

`ifdef FETCH_BYPASS_EN
  assign bypass = fifo_empty & rsp_valid;
`else
  assign bypass = 1'b0;
`endif

  assign instr_valid = ~redirect & (~fifo_empty | bypass);
  assign pop         = instr_valid & dec_ready;
  assign fifo_pop    = pop & ~bypass;
  assign push        = rsp_valid & ~(bypass & dec_ready);

  always_comb begin
    instr   = '0;
    pcplus4 = '0;
    if (~redirect & ~fifo_empty) begin
      instr   = fifo_instr[head];
      pcplus4 = fifo_pc4[head];
    end else if (bypass) begin
      instr   = imem_rdata;
      pcplus4 = tag;
    end
  end

  // Reserve a FIFO slot for every outstanding request so a response always fits.
  assign occupancy = count - CW'(pop) + CW'(inflight);
  assign imem_req  = reset & ~redirect & (occupancy < CW'(DEPTH));
  assign imem_addr = pc[AW+1:2];
  assign target    = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      inflight <= 1'b0;
      tag      <= '0;
      discard  <= 1'b0;
    end else if (redirect) begin
      pc       <= target;
      inflight <= 1'b0;
      discard  <= inflight;
    end else begin
      discard  <= 1'b0;
      inflight <= imem_req;
      if (imem_req) begin
        tag <= pc + 32'd4;
        pc  <= pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)     tail <= tail + 1'b1;
      if (fifo_pop) head <= head + 1'b1;
      count <= count + CW'(push) - CW'(fifo_pop);
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (tail == PW'(gi))) begin
        fifo_instr[gi] <= imem_rdata;
        fifo_pc4[gi]   <= tag;
      end
    end
  end

endmodule

// File: doc/mips_fetch_stage.md
# mips_fetch_stage

Instruction fetch stage for the pipelined MIPS core, sitting directly upstream of the fetch/decode pipeline register. It owns the program counter, issues word reads to a synchronous instruction memory, and buffers returned instructions tagged with PC+4 in a small FIFO. Decode consumes instructions through a valid/ready handshake. A taken branch resolved in the memory stage redirects the stage, flushing the buffered and in-flight instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
- AW, 6, instruction memory word-address width
- DEPTH, 2, instruction FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  read request this cycle
- imem_addr  out  AW  word address, equal to pc[AW+1:2]
- imem_rdata  in  32  read data, valid exactly one cycle after imem_req
- redirect  in  1  taken branch from memory stage (branchM & zeroM)
- redirect_pc  in  32  branch target (pcbranchM); bits [1:0] ignored, forced to 00
- dec_ready  in  1  decode can accept (deasserted on stall)
- instr_valid  out  1  instr/pcplus4 hold a valid instruction
- instr  out  32  instruction to decode
- pcplus4  out  32  address of instr plus 4

## Operation
- State: pc[31:0], FIFO of DEPTH entries {instr, pcplus4}, count, inflight flag with captured pcplus4 tag, and a discard flag.
- pop = instr_valid & dec_ready. Head advances on pop.
- Issue rule: imem_req = !redirect & ((count − pop + inflight) < DEPTH). On issue: inflight ← 1, tag ← pc+4, pc ← pc+4 (mod 2^32).
- Response: in the cycle after an issue, imem_rdata with its tag is pushed into the FIFO unless discard is set.
- Redirect has priority over everything. In a redirect cycle:
  - instr_valid is forced 0 and no pop occurs.
  - imem_req is 0.
  - On the edge, FIFO is cleared, pc ← {redirect_pc[31:2],2'b00}, and discard ← inflight.
- Discard clears after one cycle. The in-flight response arriving in that cycle is dropped.
- Back-to-back redirects: the last one wins; each drops any in-flight response.
- Full FIFO with dec_ready=0: no issue. pc holds and no instruction is lost.
- Simultaneous push and pop on a full FIFO is legal. count stays unchanged.
- PC wrap-around: pc+4 from 32'hFFFF_FFFC gives 32'h0000_0000. imem_addr uses low bits only.

## Timing
- Reset (asynchronous assert, synchronous release):
  - pc=RESET_PC, count=0, inflight=0, discard=0.
  - imem_req=0, instr_valid=0, instr=0, pcplus4=0.
- First imem_req occurs in the first cycle after reset deasserts.
- Default latency: request at cycle t → data enters the FIFO at edge t+1 → instr_valid at cycle t+2.
- Steady-state throughput is one instruction per cycle with dec_ready held high (DEPTH≥2).
- After a redirect in cycle r: first request at r+1 to the target, instr_valid at r+3 (r+2 with bypass).
- Reset asserted mid-operation: immediate return to reset values. In-flight data is ignored.

## Configuration
- FETCH_BYPASS_EN defined: when the FIFO is empty and a non-discarded response arrives, it is presented combinationally on instr/pcplus4 with instr_valid=1 in the same cycle (latency t+1).
  - If popped in that cycle, it is not written to the FIFO. Otherwise it is pushed normally.
- FETCH_BYPASS_EN undefined: outputs come only from the FIFO head (registered path, latency t+2).

## Test plan
- Reset release with RESET_PC=0, dec_ready=1 → imem_addr 0,1,2,… on consecutive cycles. instr_valid rises at cycle 2 (cycle 1 with bypass). pcplus4 sequence is 4,8,12….
- Hold dec_ready=0 for 5 cycles from cycle 4 → at most DEPTH instructions buffered, imem_req drops, pc holds. On release, the sequence continues with no gap or duplicate.
- Redirect at cycle 6 with redirect_pc=0x40 → instr_valid=0 at cycle 6, in-flight word dropped. Next request imem_addr=16, next delivered pcplus4=0x44.
- redirect_pc=0x43 → treated as 0x40.
- Redirects on two consecutive cycles (0x40 then 0x80) → only pcplus4=0x84 stream delivered.
- pc=32'hFFFF_FFF8 via redirect, free-running → pcplus4 sequence FFFF_FFFC, 0000_0000, 0000_0004, and imem_addr wraps.
- Assert reset while the FIFO is full → instr_valid=0 and pc=RESET_PC immediately. After release, fetch restarts cleanly.
